// File: rtl/project_pwm_pkg.sv
// Shared encodings and defaults for the PWM register-file host front end.
package project_pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_DISCARD = 3'd4
  } ctrl_state_e;

  localparam int CMD_READ_BIT          = 7;
  localparam int CMD_AINC_BIT          = 6;
  localparam int CMD_ADDR_W            = 6;
  localparam int ADDRESS_WIDTH_DEFAULT = 6;
  localparam int MAX_ADDRESS_DEFAULT   = 48;

endpackage

// File: rtl/project_input_synchronizer.sv
// Two-flop synchroniser for an asynchronous pin, plus a registered rising-edge flag
// (edge flag asserts three clocks after the pin rises).
module project_input_synchronizer (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    sync1_d = i_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign o_level = sync2_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/project_register_bus_controller.sv
// Byte-serial host front end and sole master of the PWM register file.
// Define REGFILE_CTRL_READBACK_EN to enable the read-back path; otherwise read commands are illegal.
//
// state    | meaning
// IDLE     | no frame selected
// CMD      | frame open, waiting for the command byte
// WRITE    | each byte strobe writes the register at the pointer
// READ     | each byte strobe presents the next read-back byte
// DISCARD  | illegal command, ignore strobes until frame end
module project_register_bus_controller
  import project_pwm_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int MAX_ADDRESS   = MAX_ADDRESS_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cs_n,
  input  logic                     i_strobe,
  input  logic [7:0]               i_host_data,
  output logic [7:0]               o_host_data,
  output logic                     o_host_valid,
  output logic                     o_error,
  output logic                     o_frame_active,
  output logic                     o_rf_write_en,
  output logic [ADDRESS_WIDTH-1:0] o_rf_address,
  output logic [7:0]               o_rf_data,
  input  logic [7:0]               i_rf_data
);

`ifdef REGFILE_CTRL_READBACK_EN
  localparam logic READ_OK = 1'b1;
`else
  localparam logic READ_OK = 1'b0;
`endif

  logic cs_active, cs_start, stb_edge, stb_level;

  // cs_n is inverted ahead of the synchroniser so the cleared reset value means "not selected"
  project_input_synchronizer u_sync_cs (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (~i_cs_n),
    .o_level (cs_active),
    .o_rise  (cs_start)
  );

  project_input_synchronizer u_sync_strobe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_strobe),
    .o_level (stb_level),
    .o_rise  (stb_edge)
  );

  ctrl_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     ainc_q, ainc_d;
  logic [7:0]               rf_data_q, rf_data_d;
  logic                     we_q, we_d;
  logic                     error_q, error_d;
  logic                     rd_pend_q, rd_pend_d;
  logic [CMD_ADDR_W-1:0]    cmd_addr;
  logic                     cmd_illegal;

  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a);
    if (int'(a) >= MAX_ADDRESS) return '0;
    return a + ADDRESS_WIDTH'(1);
  endfunction

  assign cmd_addr    = i_host_data[CMD_ADDR_W-1:0];
  assign cmd_illegal = (int'(cmd_addr) > MAX_ADDRESS) || (i_host_data[CMD_READ_BIT] && !READ_OK);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ainc_d    = ainc_q;
    rf_data_d = rf_data_q;
    we_d      = 1'b0;
    error_d   = error_q;
    rd_pend_d = 1'b0;
    // the pointer moves only after the write pulse so the strobe sees a stable address
    if (we_q && ainc_q) addr_d = next_addr(addr_q);
    if (!cs_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_start) begin
            state_d = ST_CMD;
            error_d = 1'b0;
          end
        end
        ST_CMD: begin
          if (stb_edge) begin
            if (cmd_illegal) begin
              state_d = ST_DISCARD;
              error_d = 1'b1;
            end else begin
              addr_d = ADDRESS_WIDTH'(cmd_addr);
              ainc_d = i_host_data[CMD_AINC_BIT];
              if (i_host_data[CMD_READ_BIT]) begin
                state_d   = ST_READ;
                rd_pend_d = 1'b1;
              end else begin
                state_d = ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (stb_edge) begin
            rf_data_d = i_host_data;
            we_d      = 1'b1;
          end
        end
        ST_READ: begin
          if (stb_edge) begin
            if (ainc_q) addr_d = next_addr(addr_q);
            rd_pend_d = 1'b1;
          end
        end
        ST_DISCARD: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      ainc_q    <= 1'b0;
      rf_data_q <= 8'h00;
      we_q      <= 1'b0;
      error_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ainc_q    <= ainc_d;
      rf_data_q <= rf_data_d;
      we_q      <= we_d;
      error_q   <= error_d;
      rd_pend_q <= rd_pend_d;
    end
  end

`ifdef REGFILE_CTRL_READBACK_EN
  logic [7:0] host_data_q, host_data_d;
  logic       host_valid_q, host_valid_d;
  logic       unused_stb_level;

  assign unused_stb_level = stb_level;

  always_comb begin
    host_data_d  = host_data_q;
    host_valid_d = rd_pend_q;
    if (rd_pend_q) host_data_d = i_rf_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      host_data_q  <= 8'h00;
      host_valid_q <= 1'b0;
    end else begin
      host_data_q  <= host_data_d;
      host_valid_q <= host_valid_d;
    end
  end

  assign o_host_data  = host_data_q;
  assign o_host_valid = host_valid_q;
`else
  logic unused_rd;
  assign unused_rd    = ^{i_rf_data, rd_pend_q, stb_level};
  assign o_host_data  = 8'h00;
  assign o_host_valid = 1'b0;
`endif

  assign o_error        = error_q;
  assign o_frame_active = (state_q != ST_IDLE) && cs_active;
  assign o_rf_write_en  = we_q;
  assign o_rf_address   = addr_q;
  assign o_rf_data      = rf_data_q;

endmodule

// File: tb/tb_project_register_bus_controller.sv
// Randomised frame-level bench for the register bus controller with a register-file model.
`timescale 1ns/1ps
module tb_project_register_bus_controller;

  localparam int MAXA = 48;
`ifdef REGFILE_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       stb = 1'b0;
  logic [7:0] hdata = 8'h00;
  logic [7:0] host_data, wdata, rf_rd;
  logic       host_valid, err, factive, we;
  logic [5:0] addr;

  logic [7:0]  rf_mem  [64];
  logic [7:0]  mdl_mem [64];
  logic [13:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  bit          prev_we;
  int          bad_we = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  assign rf_rd = rf_mem[addr];

  project_register_bus_controller dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cs_n         (cs_n),
    .i_strobe       (stb),
    .i_host_data    (hdata),
    .o_host_data    (host_data),
    .o_host_valid   (host_valid),
    .o_error        (err),
    .o_frame_active (factive),
    .o_rf_write_en  (we),
    .o_rf_address   (addr),
    .o_rf_data      (wdata),
    .i_rf_data      (rf_rd)
  );

  // register file plus bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
      for (int i = 0; i < 64; i++) rf_mem[i] = mdl_mem[i];
    end else begin
      if (we) begin
        if (prev_we || int'(addr) > MAXA) bad_we++;
        wr_q.push_back({addr, wdata});
        rf_mem[addr] = wdata;
      end
      if (host_valid) rd_q.push_back(host_data);
      prev_we = we;
    end
  end

  function automatic int nxt(input int a);
    return (a >= MAXA) ? 0 : a + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop_cs);
    hdata = b;
    tick(2);
    stb = 1'b1;
    if (drop_cs) cs_n = 1'b1;
    tick(6);
    stb = 1'b0;
    tick(4);
  endtask

  // Sends cmd plus tx_q; abort_last raises cs_n together with the last data strobe.
  task automatic run_frame(input string name, input logic [7:0] cmd, input bit abort_last);
    logic [13:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int a, n_eff, bad0;
    bit exp_err;
    n_eff = (abort_last && tx_q.size() > 0) ? tx_q.size() - 1 : tx_q.size();
    a = int'(cmd[5:0]);
    exp_err = (a > MAXA) || (cmd[7] && !RB);
    if (!exp_err) begin
      if (cmd[7]) begin
        exp_rd.push_back(mdl_mem[a]);
        for (int i = 0; i < n_eff; i++) begin
          if (cmd[6]) a = nxt(a);
          exp_rd.push_back(mdl_mem[a]);
        end
      end else begin
        for (int i = 0; i < n_eff; i++) begin
          exp_wr.push_back({6'(a), tx_q[i]});
          mdl_mem[a] = tx_q[i];
          if (cmd[6]) a = nxt(a);
        end
      end
    end

    wr_q.delete();
    rd_q.delete();
    bad0 = bad_we;
    cs_n = 1'b0;
    tick(6);
    checks++;
    if (factive !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_start: active=%b error=%b, want active=1 error=0", name, factive, err);
    end
    send_byte(cmd, 1'b0);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], abort_last && (i == tx_q.size() - 1));
    cs_n = 1'b1;
    tick(6);

    checks++;
    if (factive !== 1'b0 || err !== exp_err) begin
      failures++;
      $display("FAIL %s frame_end: active=%b error=%b, want active=0 error=%b", name, factive, err, exp_err);
    end
    checks++;
    if (wr_q.size() != exp_wr.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d, want %0d", name, wr_q.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          failures++;
          $display("FAIL %s write[%0d]: addr=%0d data=%h, want addr=%0d data=%h",
                   name, i, wr_q[i][13:8], wr_q[i][7:0], exp_wr[i][13:8], exp_wr[i][7:0]);
        end
      end
    end
    checks++;
    if (rd_q.size() != exp_rd.size()) begin
      failures++;
      $display("FAIL %s read_count: got %0d, want %0d", name, rd_q.size(), exp_rd.size());
    end else begin
      for (int i = 0; i < exp_rd.size(); i++) begin
        checks++;
        if (rd_q[i] !== exp_rd[i]) begin
          failures++;
          $display("FAIL %s read[%0d]: got %h, want %h", name, i, rd_q[i], exp_rd[i]);
        end
      end
    end
    checks++;
    if (bad_we != bad0) begin
      failures++;
      $display("FAIL %s write_rules: %0d back-to-back/out-of-range pulses, want 0", name, bad_we - bad0);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({host_data, host_valid, err, factive, we, addr, wdata} !== '0) begin
      failures++;
      $display("FAIL %s outputs: hd=%h hv=%b err=%b act=%b we=%b addr=%0d wd=%h, want all 0",
               name, host_data, host_valid, err, factive, we, addr, wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(4);
    check_outputs_zero("after_reset");
  endtask

  task automatic test_single_write();
    tx_q = '{8'hA5};
    run_frame("single", 8'h05, 1'b0);
  endtask

  task automatic test_burst();
    tx_q = '{8'h11, 8'h22, 8'h33};
    run_frame("burst", 8'h42, 1'b0);
  endtask

  task automatic test_wrap();
    tx_q = '{8'h01, 8'h02};
    run_frame("wrap", 8'h70, 1'b0);
  endtask

  task automatic test_illegal();
    tx_q = '{8'hFF};
    run_frame("illegal", 8'h3F, 1'b0);
    tx_q = '{8'h44};
    run_frame("after_illegal", 8'h07, 1'b0);
  endtask

  task automatic test_readback();
    tx_q = '{8'h9C};
    run_frame("rb_write", 8'h10, 1'b0);
    tx_q = '{8'h00};
    run_frame("rb_read", 8'hD0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int n;
    for (int f = 0; f < 24; f++) begin
      cmd = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 55))};
      n = $urandom_range(0, 4);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      run_frame($sformatf("random%0d", f), cmd, 1'b0);
    end
  endtask

  task automatic test_abort_cs();
    tx_q = '{8'h5A, 8'hC3};
    run_frame("abort_cs", 8'h4A, 1'b1);
  endtask

  task automatic test_abort_reset();
    wr_q.delete();
    cs_n = 1'b0;
    tick(6);
    send_byte(8'h48, 1'b0);
    send_byte(8'h11, 1'b0);
    mdl_mem[8] = 8'h11;
    hdata = 8'h22;
    tick(2);
    stb = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort_reset_in");
    cs_n = 1'b1;
    stb = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(6);
    check_outputs_zero("abort_reset_out");
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {6'd8, 8'h11}) begin
      failures++;
      $display("FAIL abort_reset writes: count=%0d first=%h, want count=1 first=%h",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 14'h0, {6'd8, 8'h11});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl_mem[i] = 8'($urandom);
    test_reset();
    test_single_write();
    test_burst();
    test_wrap();
    test_illegal();
    test_readback();
    test_abort_cs();
    test_random();
    test_abort_reset();
    tx_q = '{8'h77};
    run_frame("post_reset", 8'h21, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
